// File: rtl/ex_muldiv_pkg.sv
// Pipeline-wide definitions shared by the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
module muldiv_datapath
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [WIDTH:0]   hi_acc;
  logic [WIDTH-1:0] lo_acc;
  logic [WIDTH-1:0] opnd;
  logic             div_mode;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    sum     = {1'b0, hi_acc[WIDTH-1:0]} + (lo_acc[0] ? {1'b0, opnd} : '0);
    shifted = {hi_acc[WIDTH-1:0], lo_acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
  end

  // Multiply: lo_acc holds multiplier, shifted out as product bits enter from hi.
  // Divide: lo_acc holds dividend, shifted out as quotient bits enter at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_acc   <= '0;
      lo_acc   <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      hi_acc   <= '0;
      lo_acc   <= is_div ? op_a : op_b;
      opnd     <= is_div ? op_b : op_a;
      div_mode <= is_div;
    end else if (step) begin
      if (div_mode) begin
        hi_acc <= diff[WIDTH] ? shifted : diff;
        lo_acc <= {lo_acc[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
        hi_acc <= {1'b0, sum[WIDTH:1]};
        lo_acc <= {sum[0], lo_acc[WIDTH-1:1]};
      end
    end
  end

  assign hi_res = hi_acc[WIDTH-1:0];
  assign lo_res = lo_acc;

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multi-cycle MULT/DIV unit with architectural HI/LO and upstream stall.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [5:0]       funct_in,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic             kill_in,
  output logic             stall_out,
  output logic             done_out,
  output logic [WIDTH-1:0] mf_data_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  md_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic             op_div, neg_q, neg_r, div_zero;

  logic             start, commit, mt_hi, mt_lo;
  logic             f_signed, f_div, rs_neg, rt_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] dp_hi, dp_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    f_signed = (funct_in == FUNCT_MULT) || (funct_in == FUNCT_DIV);
    f_div    = (funct_in == FUNCT_DIV)  || (funct_in == FUNCT_DIVU);
    rs_neg   = f_signed & rs_in[WIDTH-1];
    rt_neg   = f_signed & rt_in[WIDTH-1];
    a_mag    = rs_neg ? -rs_in : rs_in;
    b_mag    = rt_neg ? -rt_in : rt_in;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    commit    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    stall_out = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (valid_in && !kill_in) begin
          if (is_muldiv(funct_in)) begin
            start     = 1'b1;
            stall_out = 1'b1;
            state_nxt = ST_CALC;
          end
          mt_hi = (funct_in == FUNCT_MTHI);
          mt_lo = (funct_in == FUNCT_MTLO);
        end
      end
      ST_CALC: begin
        stall_out = 1'b1;
        if (kill_in)
          state_nxt = ST_IDLE;
        else if (cnt == CW'(WIDTH - 1))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        commit    = !kill_in;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      cnt      <= '0;
      op_div   <= f_div;
      neg_q    <= rs_neg ^ rt_neg;
      neg_r    <= rs_neg;
      div_zero <= (rt_in == '0);
    end else if (state == ST_CALC) begin
      cnt <= cnt + 1'b1;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start),
    .step   (state == ST_CALC),
    .is_div (f_div),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .hi_res (dp_hi),
    .lo_res (dp_lo)
  );

  // With a zero divisor the restoring step leaves |rs| as remainder, so the
  // remainder fixup alone reproduces rs; only the quotient needs forcing.
  always_comb begin
    prod    = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
    quo_fix = div_zero ? '1 : (neg_q ? -dp_lo : dp_lo);
    rem_fix = neg_r ? -dp_hi : dp_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (op_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end
    end else begin
      if (mt_hi) hi <= rs_in;
      if (mt_lo) lo <= rs_in;
    end
  end

  assign done_out    = commit;
  assign hi_out      = hi;
  assign lo_out      = lo;
  assign mf_data_out = (funct_in == FUNCT_MFHI) ? hi : lo;

endmodule
